// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multi-cycle control unit: opcodes, FSM states,
// writeback source selects and ALU control codes.
package sisc_pkg;

  localparam int unsigned OPC_NOOP = 0;
  localparam int unsigned OPC_LOD  = 1;
  localparam int unsigned OPC_STR  = 2;
  localparam int unsigned OPC_SWP  = 3;
  localparam int unsigned OPC_BRA  = 4;
  localparam int unsigned OPC_BRR  = 5;
  localparam int unsigned OPC_BNE  = 6;
  localparam int unsigned OPC_BNR  = 7;
  localparam int unsigned OPC_ALU  = 8;
  localparam int unsigned OPC_HLT  = 15;

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_SWP = 2'd2;

  // bit1 suppresses the status save, bit0 selects the immediate operand
  localparam logic [1:0] ALU_REG    = 2'b00;
  localparam logic [1:0] ALU_IMM    = 2'b01;
  localparam logic [1:0] ALU_NOSAVE = 2'b10;
  localparam logic [1:0] ALU_ADDR   = 2'b11;

endpackage

// File: rtl/sisc_br_eval.sv
// Combinational branch resolution: a branch is taken when the masked status
// matches its polarity (BRA/BRR on any set bit, BNE/BNR on none).
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int MM_W  = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  output logic             taken,
  output logic             rel
);

  logic [31:0] opc_v;
  logic        cond;

  assign opc_v = 32'(opcode);
  assign cond  = |(stat & mm);
  assign rel   = opcode[0];

  always_comb begin
    taken = 1'b0;
    if (opc_v == OPC_BRA || opc_v == OPC_BRR) begin
      taken = cond;
    end else if (opc_v == OPC_BNE || opc_v == OPC_BNR) begin
      taken = ~cond;
    end
  end

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle SISC control FSM: sequences fetch/decode/execute/mem/writeback
// with ready/valid memory handshakes and an absorbing HALT state.
module sisc_ctrl_fsm
  import sisc_pkg::*;
#(
  parameter int OPC_W      = 4,
  parameter int MM_W       = 4,
  parameter int STAT_W     = 4,
  parameter int ALU_OP_W   = 2,
  parameter int AM_IMM     = 8,
  parameter int SWP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [MM_W-1:0]     mm,
  input  logic [STAT_W-1:0]   stat,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dm_we,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_sel,
  output logic                br_sel,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                swp_phase,
  output logic                halted
);

  localparam int CNT_W = (SWP_CYCLES > 1) ? $clog2(SWP_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   swp_cnt_q, swp_cnt_d;
  logic [31:0]        opc_v;
  logic               br_taken;
  logic               br_rel;

  assign opc_v = 32'(opcode);

  sisc_br_eval #(
    .OPC_W (OPC_W),
    .MM_W  (MM_W)
  ) u_br_eval (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (br_taken),
    .rel    (br_rel)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; the async reset drops req lines without waiting for clk.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q   <= ST_START0;
      swp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      swp_cnt_q <= swp_cnt_d;
    end
  end

  // NOTE: every output and next-state value gets a default first so no path
  // through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    swp_cnt_d = swp_cnt_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dm_we     = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    br_sel    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    alu_op    = ALU_OP_W'(ALU_NOSAVE);
    swp_phase = 1'b0;
    halted    = 1'b0;

    case (state_q)
      ST_START0: state_d = ST_START1;
      ST_START1: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: state_d = (opc_v == OPC_HLT) ? ST_HALT : ST_EXECUTE;

      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (opc_v == OPC_ALU) begin
          alu_op  = (mm == MM_W'(AM_IMM)) ? ALU_OP_W'(ALU_IMM) : ALU_OP_W'(ALU_REG);
          state_d = ST_WRITEBACK;
        end else if (opc_v == OPC_LOD || opc_v == OPC_STR) begin
          alu_op  = ALU_OP_W'(ALU_ADDR);
          state_d = ST_MEM;
        end else if (opc_v == OPC_SWP) begin
          state_d = ST_WRITEBACK;
        end else if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel;
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dm_we    = (opc_v == OPC_STR);
        alu_op   = ALU_OP_W'(ALU_ADDR);
        if (dmem_ack) begin
          state_d = (opc_v == OPC_STR) ? ST_FETCH : ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        rf_we   = 1'b1;
        state_d = ST_FETCH;
        if (opc_v == OPC_LOD) begin
          wb_sel = WB_MEM;
        end else if (opc_v == OPC_SWP) begin
          wb_sel    = WB_SWP;
          swp_phase = swp_cnt_q[0];
          // SWP holds writeback for SWP_CYCLES cycles, one register write each
          if (swp_cnt_q == CNT_W'(SWP_CYCLES - 1)) begin
            swp_cnt_d = '0;
          end else begin
            swp_cnt_d = swp_cnt_q + 1'b1;
            state_d   = ST_WRITEBACK;
          end
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_START0;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Self-checking bench for sisc_ctrl_fsm: an instruction-level timeline model
// predicts the output vector of every cycle under randomized handshake latency.
module tb_sisc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, rf_we;
  logic [1:0] wb_sel, alu_op;
  logic       swp_phase, halted;

  sisc_ctrl_fsm dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dm_we     (dm_we),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .swp_phase (swp_phase),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // {imem_req, dmem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, alu_op, swp_phase, halted}
  function automatic logic [13:0] vec(input logic ireq, input logic dreq, input logic we,
                                      input logic irl, input logic pcw, input logic pcs,
                                      input logic brs, input logic rfw, input logic [1:0] wbs,
                                      input logic [1:0] aop, input logic sp, input logic hlt);
    return {ireq, dreq, we, irl, pcw, pcs, brs, rfw, wbs, aop, sp, hlt};
  endfunction

  localparam logic [13:0] V_DEF = 14'h0008;

  logic [13:0] dut_vec;
  assign dut_vec = {imem_req, dmem_req, dm_we, ir_load, pc_write, pc_sel, br_sel, rf_we,
                    wb_sel, alu_op, swp_phase, halted};

  logic [13:0] exp_vec = V_DEF;
  logic        exp_valid = 1'b0;
  logic [3:0]  nxt_opc = '0, nxt_mm = '0, nxt_stat = '0;

  int cyc = 0, last_load = 0, prev_load = 0;
  int dmem_cnt = 0, dmwe_cnt = 0, rf_cnt = 0, pcw_cnt = 0;

  // Single compare process: samples on the falling edge, away from state updates.
  always @(negedge clk) begin
    cyc++;
    if (dmem_req) dmem_cnt++;
    if (dm_we)    dmwe_cnt++;
    if (rf_we)    rf_cnt++;
    if (pc_write) pcw_cnt++;
    if (ir_load) begin
      prev_load = last_load;
      last_load = cyc;
    end
    if (exp_valid) check("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
  end

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cycle(input logic [13:0] e, input logic ia, input logic da);
    @(posedge clk);
    #1;
    opcode    = nxt_opc;
    mm        = nxt_mm;
    stat      = nxt_stat;
    imem_ack  = ia;
    dmem_ack  = da;
    exp_vec   = e;
    exp_valid = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    exp_valid = 1'b0;
  endtask

  // Reset is released one cycle into START0; START1 follows, then FETCH.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_f     = 1'b0;
    imem_ack  = rnd();
    dmem_ack  = rnd();
    exp_vec   = V_DEF;
    exp_valid = 1'b1;
    cycle(V_DEF, rnd(), rnd());
  endtask

  // Instruction-level model: lays out the expected cycle-by-cycle outputs of one
  // instruction from fetch to its last cycle, given the chosen handshake waits.
  task automatic run_instr(input int opc, input logic [3:0] m, input logic [3:0] st,
                           input int iw, input int dw, input int halt_cycles);
    logic       cond, taken, is_ls, is_br;
    logic [1:0] ex_alu;
    nxt_opc  = 4'(opc);
    nxt_mm   = m;
    nxt_stat = st;
    for (int i = 0; i < iw; i++)
      cycle(vec(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'b10, 0, 0), 1'b0, rnd());
    cycle(vec(1, 0, 0, 1, 1, 0, 0, 0, 2'd0, 2'b10, 0, 0), 1'b1, rnd());
    cycle(V_DEF, rnd(), rnd());
    if (opc == 15) begin
      for (int i = 0; i < halt_cycles; i++)
        cycle(vec(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'b10, 0, 1), rnd(), rnd());
      return;
    end
    is_ls = (opc == 1 || opc == 2);
    is_br = (opc >= 4 && opc <= 7);
    cond  = ((st & m) != 4'd0);
    taken = is_br && ((opc <= 5) ? cond : !cond);
    if (opc == 8)  ex_alu = (m == 4'd8) ? 2'b01 : 2'b00;
    else if (is_ls) ex_alu = 2'b11;
    else            ex_alu = 2'b10;
    cycle(vec(0, 0, 0, 0, taken, taken, taken && (opc == 5 || opc == 7), 0, 2'd0, ex_alu, 0, 0),
          rnd(), rnd());
    if (is_ls) begin
      for (int i = 0; i < dw; i++)
        cycle(vec(0, 1, opc == 2, 0, 0, 0, 0, 0, 2'd0, 2'b11, 0, 0), rnd(), 1'b0);
      cycle(vec(0, 1, opc == 2, 0, 0, 0, 0, 0, 2'd0, 2'b11, 0, 0), rnd(), 1'b1);
    end
    if (opc == 8 || opc == 1)
      cycle(vec(0, 0, 0, 0, 0, 0, 0, 1, (opc == 1) ? 2'd1 : 2'd0, 2'b10, 0, 0), rnd(), rnd());
    if (opc == 3)
      for (int k = 0; k < 2; k++)
        cycle(vec(0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'b10, 1'(k), 0), rnd(), rnd());
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      run_instr(int'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 0);
  endtask

  int d_dmem, d_dmwe, d_rf, d_pcw;
  task automatic snap();
    d_dmem = dmem_cnt;
    d_dmwe = dmwe_cnt;
    d_rf   = rf_cnt;
    d_pcw  = pcw_cnt;
  endtask

  initial begin
    rst_f    = 1'b1;
    opcode   = '0;
    mm       = '0;
    stat     = '0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(dut_vec), 32'h0008);
    release_reset();

    // ADI twice with zero-wait imem: fetch-to-fetch is 4 cycles
    run_instr(8, 4'd8, 4'd0, 0, 0, 0);
    run_instr(8, 4'd8, 4'd0, 0, 0, 0);
    settle();
    check("adi_cpi", 32'(last_load - prev_load), 32'd4);

    snap();
    run_instr(1, 4'd3, 4'd0, 1, 3, 0);
    settle();
    check("lod_dmem_req_cycles", 32'(dmem_cnt - d_dmem), 32'd4);
    check("lod_dm_we_cycles", 32'(dmwe_cnt - d_dmwe), 32'd0);
    check("lod_rf_we_cycles", 32'(rf_cnt - d_rf), 32'd1);

    snap();
    run_instr(2, 4'd3, 4'd0, 0, 0, 0);
    settle();
    check("str_dm_we_cycles", 32'(dmwe_cnt - d_dmwe), 32'd1);
    check("str_rf_we_cycles", 32'(rf_cnt - d_rf), 32'd0);

    snap();
    run_instr(6, 4'b0010, 4'b0010, 0, 0, 0);
    settle();
    check("bne_not_taken_pc_writes", 32'(pcw_cnt - d_pcw), 32'd1);

    snap();
    run_instr(6, 4'b0010, 4'b0100, 0, 0, 0);
    settle();
    check("bne_taken_pc_writes", 32'(pcw_cnt - d_pcw), 32'd2);

    snap();
    run_instr(3, 4'd0, 4'd0, 2, 0, 0);
    settle();
    check("swp_rf_we_cycles", 32'(rf_cnt - d_rf), 32'd2);

    run_random(60);

    // Reset in the middle of a stalled fetch
    nxt_opc = 4'd8;
    cycle(vec(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'b10, 0, 0), 1'b0, 1'b0);
    cycle(vec(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'b10, 0, 0), 1'b0, 1'b0);
    #2;
    exp_valid = 1'b0;
    rst_f     = 1'b1;
    #1;
    check("rst_drops_imem_req", 32'(imem_req), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
    end
    @(negedge clk);
    check("rst_hold_outputs", 32'(dut_vec), 32'h0008);
    release_reset();
    run_random(5);

    run_instr(15, 4'd0, 4'd0, 1, 0, 100);
    #1;
    check("halt_after_100", 32'(halted), 32'd1);
    exp_valid = 1'b0;
    rst_f     = 1'b1;
    #1;
    check("halt_reset_clears", 32'(halted), 32'd0);
    check("halt_reset_outputs", 32'(dut_vec), 32'h0008);
    @(posedge clk);
    release_reset();
    run_random(3);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl_fsm.md
Name: sisc_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the SISC processor. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for the full instruction set: ALU, LOD, STR, SWP, branches and HLT. Instruction and data memory are accessed through ready/valid handshakes with variable latency, and branches are resolved against the status register. HLT enters a real HALT state instead of stopping simulation. The block drives the datapath (rf, alu, mux32, pc, ir, dm).

Parameters:
OPC_W, 4, opcode field width (instr[31:28] at default)
MM_W, 4, mode/condition field width (instr[27:24] at default)
STAT_W, 4, status register width; must equal MM_W
ALU_OP_W, 2, alu_op width; bit1 = no status save, bit0 = use immediate
AM_IMM, 8, mm value selecting immediate operand for ALU_OP
SWP_CYCLES, 2, writeback cycles used by SWP (two register writes)

Ports:
clk  input  1  system clock, posedge active
rst_f  input  1  asynchronous reset, active-high
opcode  input  OPC_W  current instruction opcode from ir
mm  input  MM_W  addressing mode / branch condition mask
stat  input  STAT_W  status register output
imem_ack  input  1  instruction memory data valid for current request
dmem_ack  input  1  data memory access complete
imem_req  output  1  instruction fetch request, held until imem_ack
dmem_req  output  1  data access request, held until dmem_ack
dm_we  output  1  data memory write enable; valid with dmem_req
ir_load  output  1  latch instruction register
pc_write  output  1  update PC
pc_sel  output  1  0 = pc+1, 1 = branch target
br_sel  output  1  0 = absolute target (BRA/BNE), 1 = relative (BRR/BNR)
rf_we  output  1  register file write enable
wb_sel  output  2  0 = alu_result, 1 = dmem data, 2 = swap source
alu_op  output  ALU_OP_W  ALU control
swp_phase  output  1  selects second SWP write in writeback
halted  output  1  high while in HALT

Behaviour:
- States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. One registered state vector with a separate combinational next-state block. All outputs are decoded from state (Moore), except that imem_ack/dmem_ack gate ir_load and leaving a state.
- Reset (rst_f=1, asynchronous): state=START0, swp counter=0. All outputs are 0 except alu_op=2'b10. While reset is held the state stays START0.
- START0 -> START1 -> FETCH, unconditional, one cycle each.
- FETCH: imem_req=1. When imem_ack=1 in the same cycle: ir_load=1, pc_write=1, pc_sel=0, next state DECODE. Otherwise remain in FETCH with all other outputs at default.
- DECODE: one cycle, no side effects. opcode==HLT (15) -> HALT, else -> EXECUTE.
- EXECUTE:
  - ALU_OP: alu_op=2'b01 if mm==AM_IMM, else 2'b00 (status saved this cycle only).
  - LOD/STR: alu_op=2'b11 (address compute, no status).
  - Branches, cond=|(stat & mm): BRA/BRR taken if cond==1; BNE/BNR taken if cond==0. When taken, pc_write=1, pc_sel=1, br_sel=opcode[0]. Next state FETCH.
  - NOOP -> FETCH.
  - LOD/STR -> MEM. ALU_OP/SWP -> WRITEBACK.
  - Unknown opcode is treated as NOOP.
- MEM: dmem_req=1, dm_we=(opcode==STR), alu_op=2'b11. Wait until dmem_ack, then LOD -> WRITEBACK, STR -> FETCH.
- WRITEBACK: rf_we=1, alu_op=2'b10. wb_sel=0 for ALU_OP, 1 for LOD, 2 for SWP.
  - SWP stays SWP_CYCLES cycles, with swp_phase = counter LSB; counter clears on exit.
  - Exit to FETCH.
- HALT: halted=1. Absorbing state; only reset leaves it.
- Only EXECUTE ALU_OP clears alu_op bit1, so status is never saved in MEM or WRITEBACK.
- Reset mid-handshake aborts immediately: req lines drop asynchronously and a pending ack is ignored.
- An ack arriving while the block is in a state that does not assert the corresponding req is ignored.
- Branch latency from DECODE: 2 cycles to the next FETCH. ALU instruction with 0-wait imem: 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK).

Decomposition:
- Package sisc_pkg holds opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15), the state encoding, wb_sel encodings and alu_op encodings.
- One sub-module, sisc_br_eval, is natural: combinational branch-taken evaluation from opcode, mm and stat.

Test Plan:
- Reset pulse mid-FETCH with imem_req=1 -> imem_req=0 immediately; START0, START1, FETCH follow after release.
- ADI (opcode=8, mm=8) with imem_ack held 1 -> alu_op=01 in EXECUTE; rf_we=1, wb_sel=0 in WRITEBACK; next FETCH 4 cycles after the first.
- LOD with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dm_we=0; WRITEBACK wb_sel=1; STR variant -> dm_we=1, no rf_we.
- BNE with mm=4'b0010: stat=4'b0010 -> not taken, no pc_write in EXECUTE; stat=4'b0100 -> pc_write=1, pc_sel=1, br_sel=0.
- SWP -> rf_we=1 for 2 cycles, swp_phase 0 then 1, wb_sel=2.
- HLT -> halted=1 and stays for 100 cycles ignoring acks; rst_f pulse -> START0.
